// File: rtl/mul_seq_ctrl.sv
// Keypad multiplier sequencer: captures two operands from key strobes, runs a
// WIDTH-clock shift-add multiply, then holds operands and product for display.
module mul_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [WIDTH-1:0]   key_code,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               key_drop,
  output logic [1:0]         phase
);

  localparam logic [1:0] GET_A = 2'd0;
  localparam logic [1:0] GET_B = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] SHOW  = 2'd3;

  localparam int PW = 2 * WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [IW-1:0]    iter;
  logic [PW-1:0]    acc_next;

  // Accumulator value after the current iteration; also the final product
  // on the last iteration so the product register sees that iteration's add.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // busy decodes registered state only, so it stays glitch-free and input-independent.
  assign busy = (phase == MUL);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain iterations within one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= GET_A;
      op_a     <= '0;
      op_b     <= '0;
      product  <= '0;
      done     <= 1'b0;
      key_drop <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      iter     <= '0;
    end else begin
      done     <= 1'b0;
      key_drop <= 1'b0;
      case (phase)
        GET_A, SHOW: begin
          if (key_valid) begin
            op_a    <= key_code;
            op_b    <= '0;
            product <= '0;
            phase   <= GET_B;
          end
        end
        GET_B: begin
          if (key_valid) begin
            op_b   <= key_code;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= key_code;
            iter   <= IW'(WIDTH - 1);
            phase  <= MUL;
          end
        end
        MUL: begin
          acc      <= acc_next;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          iter     <= iter - 1'b1;
          key_drop <= key_valid;
          if (iter == '0) begin
            product <= acc_next;
            phase   <= SHOW;
            done    <= 1'b1;
          end
        end
        default: phase <= GET_A;
      endcase
    end
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Controller that sequences the keypad-driven 4x4 multiplier path. It captures two operands from successive debounced key strobes and runs an iterative shift-add multiply over WIDTH clocks. It then holds the product for the BCD/seven-segment display chain. It replaces edge-clocked operand capture with a single-clock FSM and exports operands, product and phase for the display blocks.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; multiply takes WIDTH iteration clocks.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe: a debounced key press is present on key_code
key_code  input  WIDTH  key value from keypad decoder, sampled only when key_valid=1
op_a  output  WIDTH  captured first operand (to operand display)
op_b  output  WIDTH  captured second operand (to operand display)
product  output  2*WIDTH  registered result (to binary-to-BCD converter)
busy  output  1  high while phase=MUL
done  output  1  one-cycle pulse in the first SHOW cycle
key_drop  output  1  one-cycle pulse when a key_valid is ignored
phase  output  2  FSM state: 0=GET_A, 1=GET_B, 2=MUL, 3=SHOW

Behaviour:
- Reset (sync, highest priority, including mid-MUL):
  - phase=GET_A; op_a, op_b, product = 0.
  - busy, done, key_drop = 0.
  - Internal accumulator, shift registers and iteration counter cleared.
- All outputs are registered; none is combinational from inputs.
- GET_A:
  - key_valid=1 -> op_a<=key_code, op_b<=0, product<=0, phase<=GET_B.
  - Otherwise hold.
- GET_B:
  - key_valid=1 -> op_b<=key_code, phase<=MUL.
  - Load acc<=0, mcand<=zero-extended op_a (2*WIDTH bits), mplier<=key_code, iter<=WIDTH-1.
- MUL, one iteration per clock:
  - If mplier[0]=1, acc<=acc+mcand; mcand<=mcand<<1; mplier<=mplier>>1; iter<=iter-1.
  - On the iteration with iter=0: product<=final acc (including that iteration's add), phase<=SHOW, done<=1 for the next cycle only.
- Latency: if B is accepted at edge k, product is valid and done=1 in the cycle after edge k+WIDTH (4 clocks for WIDTH=4). busy=1 exactly WIDTH cycles.
- Width rules:
  - acc is 2*WIDTH bits and never overflows, since the maximum is (2^WIDTH-1)^2.
  - All operands are unsigned.
- Keys during MUL: ignored; operands and acc are unaffected; key_drop<=1 for one cycle.
- SHOW:
  - product, op_a and op_b are held indefinitely.
  - key_valid=1 -> start a new entry with the same action as GET_A (op_a<=key_code, op_b<=0, product<=0, phase<=GET_B).
- key_drop: asserted only for a key ignored in MUL; 0 otherwise.
- done: never asserted other than at the MUL->SHOW transition.
- key_valid held high for multiple cycles: each high cycle counts as a new press. The upstream debounce guarantees single-cycle strobes.
- Operand value 0 is legal for either operand. The multiply still takes WIDTH cycles, and the product is 0.

Test Plan:
1. Reset, then key 7 -> phase=1, op_a=7, op_b=0, product=0. Then key 9 -> busy for 4 cycles; done pulses once with product=0x3F (63); phase=3.
2. Keys 15, 15 -> product=0xE1 (225) after 4 clocks, with no overflow or truncation.
3. Keys 0, 13 -> busy 4 cycles, product=0, done pulses once.
4. Keys 5, 6, then key_valid with key_code=2 in the second MUL cycle -> key_drop pulses one cycle; op_a=5, op_b=6 unchanged; product=0x1E (30) on schedule.
5. Keys 3, 4, then reset asserted in the third MUL cycle -> next cycle phase=0, all outputs 0, done never pulses. Then keys 2, 2 -> product=4.
6. From SHOW with product=0x3F, key 3 -> op_a=3, op_b=0, product=0, phase=1, done=0.
